// File: rtl/spi_pkg.sv
// Shared types for the SPI request arbiter and the SPI clock generator it drives.
package spi_pkg;
    localparam int SPI_MAX_WIDTH_LOG_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_t;

    typedef logic [SPI_MAX_WIDTH_LOG_DEF:0] spi_width_t;
endpackage

// File: rtl/spi_req_arb_if.sv
// Client and generator side signals of the SPI request arbiter.
interface spi_req_arb_if
    import spi_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WL      = SPI_MAX_WIDTH_LOG_DEF
);
    // Handshake: req[i] is a level held until done[i]; done[i] is a one-cycle
    // acknowledge (with err on failure). spi_start is a one-cycle command and
    // only the first cycle of spi_finish in WAIT counts as the reply.
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_cpol;
    logic [NUM_REQ*(WL+1)-1:0] req_width;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic                      err;
    logic                      busy;
    logic                      spi_start;
    logic                      cpol;
    logic [WL:0]               spi_width;
    logic                      spi_finish;
    arb_state_t                state;

    modport master (
        input  req, req_cpol, req_width, spi_finish,
        output gnt, done, err, busy, spi_start, cpol, spi_width, state
    );

    modport slave (
        output req, req_cpol, req_width, spi_finish,
        input  gnt, done, err, busy, spi_start, cpol, spi_width, state
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, with wrap.
module rr_pick #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          valid
);
    logic [PW-1:0] pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = PW'((int'(ptr) + k) % N);
            if (!valid && req[pos]) begin
                valid    = 1'b1;
                idx      = pos;
                gnt[pos] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/spi_req_arb.sv
// Round-robin arbiter/sequencer sharing one SPI clock generator between requesters.
// Optional watchdog on the generator's finish flag: define SPI_ARB_TIMEOUT_EN.
module spi_req_arb
    import spi_pkg::*;
#(
    parameter int NUM_REQ           = 4,
    parameter int SPI_MAX_WIDTH_LOG = SPI_MAX_WIDTH_LOG_DEF,
    parameter int GAP_CYCLES        = 2,
    parameter int TIMEOUT_CYCLES    = 4096
) (
    input logic          clk,
    input logic          rst_n,
    spi_req_arb_if.master bus
);
    localparam int WW = SPI_MAX_WIDTH_LOG + 1;
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    arb_state_t       state_q, state_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d, done_q, done_d;
    logic             err_q, err_d, start_q, start_d, busy_q, busy_d, cpol_q, cpol_d;
    logic [WW-1:0]    width_q, width_d, sel_width;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [PW-1:0]      pick_idx;
    logic               pick_valid;
    logic               wd_hit, wait_end, wait_err;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        sel_width = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == PW'(i)) sel_width = bus.req_width[i*WW +: WW];
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wd_cnt_q;

    // Counter is held at zero outside WAIT, so every entry into WAIT starts fresh.
    always_ff @(posedge clk) begin
        if (!rst_n || state_q != ST_WAIT) wd_cnt_q <= '0;
        else                              wd_cnt_q <= wd_cnt_q + TW'(1);
    end
    assign wd_hit = (state_q == ST_WAIT) && (wd_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign wd_hit = 1'b0;
`endif

    assign wait_end = (state_q == ST_WAIT) && (bus.spi_finish || wd_hit);
    assign wait_err = (state_q == ST_WAIT) && !bus.spi_finish && wd_hit;

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gap_cnt_q <= '0;
            ptr_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            cpol_q    <= 1'b0;
            width_q   <= '0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            cpol_q    <= cpol_d;
            width_q   <= width_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = '0;
        case (state_q)
            ST_IDLE:  if (pick_valid) state_d = (sel_width != '0) ? ST_START : ST_GAP;
            ST_START: state_d = ST_WAIT;
            ST_WAIT:  if (wait_end) state_d = ST_GAP;
            ST_GAP: begin
                if (gap_cnt_q == GW'(GAP_CYCLES - 1)) state_d = ST_IDLE;
                else gap_cnt_d = gap_cnt_q + GW'(1);
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Zero-width requests never show gnt: they complete with err straight into GAP.
    always_comb begin
        gnt_d   = gnt_q;
        done_d  = '0;
        err_d   = 1'b0;
        cpol_d  = cpol_q;
        width_d = width_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    cpol_d  = bus.req_cpol[pick_idx];
                    width_d = sel_width;
                    ptr_d   = (pick_idx == PW'(NUM_REQ - 1)) ? '0 : pick_idx + PW'(1);
                    if (sel_width != '0) begin
                        gnt_d = pick_gnt;
                    end else begin
                        gnt_d  = '0;
                        done_d = pick_gnt;
                        err_d  = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_end) begin
                    done_d = gnt_q;
                    err_d  = wait_err;
                    gnt_d  = '0;
                end
            end
            ST_GAP:  gnt_d = '0;
            default: ;
        endcase
        start_d = (state_d == ST_START);
        busy_d  = (state_d != ST_IDLE);
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;
    assign bus.spi_start = start_q;
    assign bus.cpol      = cpol_q;
    assign bus.spi_width = width_q;
    assign bus.state     = state_q;
endmodule
